mem_access_stage: RTL and testbench
===================================

// Module: mem_access_stage
// PURPOSE
//  Pipeline MEM stage, directly downstream of EXE and upstream of WB.
//  Consumes EXE's IR_out/PC_out/Z/Addr and performs LW/LH/LD loads and SW/SH/SD stores.
//  Uses a req/ack data-memory port and stalls the upstream stages while an access is outstanding.
//  Non-memory instructions pass through with one cycle of latency.
// PARAMETERS
//  WIDTH      32          datapath width (matches `WIDTH); PC is WIDTH-2 bits
//  NOP_IR     32'h0       IR value inserted as a bubble (all-zero NOP encoding)
// PORTS
//  clk         in   1         rising-edge clock
//  rst         in   1         synchronous, active-high reset
//  IR_in       in   WIDTH     instruction from EXE
//  PC_in       in   WIDTH-2   PC from EXE
//  Z_in        in   WIDTH     ALU result, or store data for SW/SH/SD
//  Addr_in     in   WIDTH     effective byte address for loads/stores
//  MemStall    out  1         combinational; high = EXE and earlier stages must hold
//  IR_out      out  WIDTH     instruction to WB
//  PC_out      out  WIDTH-2   PC to WB
//  Z_out       out  WIDTH     ALU result passthrough
//  LMD         out  WIDTH     load data (low word for LD)
//  LMD_hi      out  WIDTH     high word for LD; 0 for all other opcodes
//  MisAlign    out  1         one-cycle pulse: a misaligned access was dropped
//  mem_req     out  1         memory request, registered
//  mem_we      out  1         1 = write
//  mem_addr    out  WIDTH     word-aligned byte address ([1:0] = 0)
//  mem_wdata   out  WIDTH     write data, lane-aligned
//  mem_be      out  4         byte enables
//  mem_rdata   in   WIDTH     read data; valid when mem_ack = 1
//  mem_ack     in   1         one-cycle completion strobe
// BEHAVIOUR
//  Reset (rst=1 at posedge):
//   - state=IDLE; IR_out=NOP_IR; PC_out, Z_out, LMD, LMD_hi = 0
//   - mem_req, mem_we, mem_be, mem_addr, mem_wdata, MisAlign = 0
//   - Reset mid-access drops mem_req at that same edge. Any later mem_ack while IDLE is ignored.
//  FSM states: IDLE, ACC1, ACC2.
//  IDLE, non-memory opcode:
//   - IR/PC/Z register to the outputs next edge; LMD=0, LMD_hi=0; MemStall=0.
//  IDLE, memory opcode, aligned:
//   - MemStall=1 (combinational). Capture op, Addr_in and Z_in; next state ACC1.
//   - Assert mem_req with address/data/be; IR_out<=NOP_IR (bubble).
//  Alignment rules:
//   - LW/SW/LD/SD need Addr[1:0]=0; LH/SH need Addr[0]=0.
//   - Misaligned: no memory access, MisAlign=1 for 1 cycle, IR_out<=NOP_IR, MemStall=0.
//  ACC1 / ACC2:
//   - mem_req, mem_we, mem_addr, mem_wdata and mem_be hold stable until mem_ack.
//   - MemStall=1 except in the cycle that carries the final mem_ack.
//   - While waiting, IR_out stays NOP_IR.
//  ACC1 + mem_ack:
//   - LW: LMD<=rdata.
//   - LH: LMD<=sign-extended halfword, taken from rdata[31:16] if Addr[1] else rdata[15:0].
//   - LD/SD: not final. LMD<=rdata for LD; next state ACC2 with mem_addr+4, mem_req held high.
//   - Otherwise final: outputs <= captured IR/PC/Z; go IDLE.
//  ACC2 + mem_ack: LD: LMD_hi<=rdata. Final: outputs update, go IDLE.
//  Store lanes:
//   - SW: be=4'b1111, wdata=Z.
//   - SH: be=Addr[1] ? 4'b1100 : 4'b0011, halfword Z[15:0] replicated to both lanes.
//   - SD: beat 1 = Z, beat 2 = 0; the upper word is not held in EXE.
//  Handshake and ordering:
//   - mem_req drops the edge after the final ack. Back-to-back memory ops re-enter ACC1 via IDLE: 1 idle cycle minimum.
//   - Final ack cycle: MemStall=0, so EXE advances on the same edge the result retires. No instruction is lost or duplicated.
//   - Total latency for a memory op = 1 + ack wait cycles, per beat.
//   - Unknown opcodes are treated as non-memory passthrough.
// TESTING
//  1 ADD passthrough: IR=ADD, Z_in=5 -> next cycle IR_out=ADD, Z_out=5, MemStall stays 0.
//  2 LW, Addr=0x100, ack after 3 cycles, rdata=0xDEADBEEF:
//    mem_req high 3 cycles, addr=0x100, be=F, MemStall high until ack cycle;
//    then LMD=0xDEADBEEF, IR_out=LW.
//  3 LH, Addr=0x102, rdata=0x8001_0000 -> be=4'b1100 read, LMD=0xFFFF8001.
//    SH, Addr=0x102, Z=0x1234 -> be=4'b1100, wdata=0x12341234.
//  4 LD at 0x200 -> two beats at 0x200 then 0x204; LMD=beat1 data, LMD_hi=beat2 data;
//    mem_req continuous across beats.
//  5 LW at Addr=0x101 -> MisAlign pulse, mem_req stays 0, IR_out=NOP_IR, no stall.
//  6 rst asserted during ACC1 wait -> next edge mem_req=0, IR_out=NOP_IR;
//    a later ack is ignored and the following ADD passes through normally.

Source files
------------

// File: rtl/mem_access_stage.sv
// mem_access_stage
//   Pipeline MEM stage between EXE and WB. Non-memory instructions pass
//   through with one cycle of latency. LW/LH/LD loads and SW/SH/SD stores
//   go through a req/ack data-memory port. LD/SD take two beats, the second
//   at address+4. While an access is outstanding, MemStall holds EXE and the
//   earlier stages, and a NOP bubble is presented to WB.
//
//   Opcode field is IR[WIDTH-1 -: 6]:
//     LW=6'h23 LH=6'h21 LD=6'h37 SW=6'h2B SH=6'h29 SD=6'h3F
//   Any other opcode is a passthrough.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   IR_in/PC_in/Z_in/Addr_in      instruction, PC, ALU result/store data and
//                                 byte address from EXE
//   MemStall                      combinational hold request to EXE
//   IR_out/PC_out/Z_out           registered instruction, PC and ALU result to WB
//   LMD/LMD_hi                    load data (LMD_hi holds the upper word, LD only)
//   MisAlign                      one-cycle pulse when a misaligned access is dropped
//   mem_req/mem_we/mem_addr/
//   mem_wdata/mem_be              registered data-memory request
//   mem_rdata/mem_ack             memory read data and completion strobe
module mem_access_stage #(
  parameter int unsigned      WIDTH  = 32,
  parameter logic [WIDTH-1:0] NOP_IR = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] IR_in,
  input  logic [WIDTH-3:0] PC_in,
  input  logic [WIDTH-1:0] Z_in,
  input  logic [WIDTH-1:0] Addr_in,
  output logic             MemStall,
  output logic [WIDTH-1:0] IR_out,
  output logic [WIDTH-3:0] PC_out,
  output logic [WIDTH-1:0] Z_out,
  output logic [WIDTH-1:0] LMD,
  output logic [WIDTH-1:0] LMD_hi,
  output logic             MisAlign,
  output logic             mem_req,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  output logic [3:0]       mem_be,
  input  logic [WIDTH-1:0] mem_rdata,
  input  logic             mem_ack
);

  localparam logic [5:0] OP_LW = 6'h23;
  localparam logic [5:0] OP_LH = 6'h21;
  localparam logic [5:0] OP_LD = 6'h37;
  localparam logic [5:0] OP_SW = 6'h2B;
  localparam logic [5:0] OP_SH = 6'h29;
  localparam logic [5:0] OP_SD = 6'h3F;

  typedef enum logic [1:0] {IDLE, ACC1, ACC2} state_t;

  state_t           state;
  logic [WIDTH-1:0] ir_q;
  logic [WIDTH-3:0] pc_q;
  logic [WIDTH-1:0] z_q;
  logic             addr1_q;

  logic [5:0]       op_in;
  logic [5:0]       op_q;
  logic             is_mem;
  logic             is_store;
  logic             is_half;
  logic             aligned;
  logic [3:0]       be_c;
  logic [WIDTH-1:0] wdata_c;
  logic [15:0]      half_c;
  logic             dbl_q;

  assign op_in  = IR_in[WIDTH-1 -: 6];
  assign op_q   = ir_q[WIDTH-1 -: 6];
  assign dbl_q  = (op_q == OP_LD) || (op_q == OP_SD);
  assign half_c = addr1_q ? mem_rdata[31:16] : mem_rdata[15:0];

  // Decode of the instruction currently presented by EXE.
  always_comb begin
    is_mem   = 1'b0;
    is_store = 1'b0;
    is_half  = 1'b0;
    case (op_in)
      OP_LW, OP_LD: is_mem = 1'b1;
      OP_LH:        begin is_mem = 1'b1; is_half = 1'b1; end
      OP_SW, OP_SD: begin is_mem = 1'b1; is_store = 1'b1; end
      OP_SH:        begin is_mem = 1'b1; is_store = 1'b1; is_half = 1'b1; end
      default:      is_mem = 1'b0;
    endcase
    aligned = is_half ? ~Addr_in[0] : (Addr_in[1:0] == 2'b00);
    if (is_half) begin
      be_c    = Addr_in[1] ? 4'b1100 : 4'b0011;
      wdata_c = {(WIDTH/16){Z_in[15:0]}};
    end else begin
      be_c    = 4'b1111;
      wdata_c = Z_in;
    end
  end

  // Stall drops in the cycle carrying the final ack so EXE advances on the
  // same edge the memory instruction retires.
  always_comb begin
    MemStall = 1'b0;
    case (state)
      IDLE:    MemStall = is_mem & aligned;
      ACC1:    MemStall = ~(mem_ack & ~dbl_q);
      ACC2:    MemStall = ~mem_ack;
      default: MemStall = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ir_q      <= NOP_IR;
      pc_q      <= '0;
      z_q       <= '0;
      addr1_q   <= 1'b0;
      IR_out    <= NOP_IR;
      PC_out    <= '0;
      Z_out     <= '0;
      LMD       <= '0;
      LMD_hi    <= '0;
      MisAlign  <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
    end else begin
      MisAlign <= 1'b0;
      case (state)
        IDLE: begin
          if (is_mem && aligned) begin
            ir_q      <= IR_in;
            pc_q      <= PC_in;
            z_q       <= Z_in;
            addr1_q   <= Addr_in[1];
            mem_req   <= 1'b1;
            mem_we    <= is_store;
            mem_addr  <= {Addr_in[WIDTH-1:2], 2'b00};
            mem_wdata <= wdata_c;
            mem_be    <= be_c;
            IR_out    <= NOP_IR;
            state     <= ACC1;
          end else if (is_mem) begin
            MisAlign <= 1'b1;
            IR_out   <= NOP_IR;
            LMD      <= '0;
            LMD_hi   <= '0;
          end else begin
            IR_out <= IR_in;
            PC_out <= PC_in;
            Z_out  <= Z_in;
            LMD    <= '0;
            LMD_hi <= '0;
          end
        end

        ACC1: begin
          if (mem_ack) begin
            case (op_q)
              OP_LD: begin
                LMD      <= mem_rdata;
                mem_addr <= mem_addr + WIDTH'(4);
                state    <= ACC2;
              end
              OP_SD: begin
                // Upper store word is not carried by EXE; beat 2 writes zero.
                LMD       <= '0;
                mem_addr  <= mem_addr + WIDTH'(4);
                mem_wdata <= '0;
                state     <= ACC2;
              end
              default: begin
                if (op_q == OP_LW)      LMD <= mem_rdata;
                else if (op_q == OP_LH) LMD <= {{(WIDTH-16){half_c[15]}}, half_c};
                else                    LMD <= '0;
                LMD_hi  <= '0;
                IR_out  <= ir_q;
                PC_out  <= pc_q;
                Z_out   <= z_q;
                mem_req <= 1'b0;
                mem_we  <= 1'b0;
                mem_be  <= '0;
                state   <= IDLE;
              end
            endcase
          end
        end

        ACC2: begin
          if (mem_ack) begin
            LMD_hi  <= (op_q == OP_LD) ? mem_rdata : '0;
            IR_out  <= ir_q;
            PC_out  <= pc_q;
            Z_out   <= z_q;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            mem_be  <= '0;
            state   <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Testbench for mem_access_stage: the bench plays EXE (holding its
// instruction while MemStall is high) and a data memory with random or
// fixed ack latency. Expected retirements, memory beats and misalign
// pulses come from an instruction-level model of the stage.
module tb_mem_access_stage;

  localparam int          W   = 32;
  localparam logic [31:0] NOP = 32'h0;

  localparam logic [5:0] OP_LW = 6'h23;
  localparam logic [5:0] OP_LH = 6'h21;
  localparam logic [5:0] OP_LD = 6'h37;
  localparam logic [5:0] OP_SW = 6'h2B;
  localparam logic [5:0] OP_SH = 6'h29;
  localparam logic [5:0] OP_SD = 6'h3F;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   IR_in, Z_in, Addr_in;
  logic [29:0]   PC_in;
  logic          MemStall;
  logic [31:0]   IR_out, Z_out, LMD, LMD_hi;
  logic [29:0]   PC_out;
  logic          MisAlign;
  logic          mem_req, mem_we;
  logic [31:0]   mem_addr, mem_wdata, mem_rdata;
  logic [3:0]    mem_be;
  logic          mem_ack;

  mem_access_stage #(.WIDTH(W), .NOP_IR(NOP)) dut (
    .clk(clk), .rst(rst), .IR_in(IR_in), .PC_in(PC_in), .Z_in(Z_in),
    .Addr_in(Addr_in), .MemStall(MemStall), .IR_out(IR_out), .PC_out(PC_out),
    .Z_out(Z_out), .LMD(LMD), .LMD_hi(LMD_hi), .MisAlign(MisAlign),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] ir;
    logic [29:0] pc;
    logic [31:0] z;
    logic [31:0] lmd;
    logic [31:0] hi;
  } ret_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } txn_t;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  ret_t        exp_ret[$];
  txn_t        exp_txn[$];
  logic [31:0] model_mem [int unsigned];
  logic [31:0] bus_mem   [int unsigned];
  logic [31:0] p_ir[$], p_z[$], p_addr[$];
  logic [29:0] p_pc[$];

  int unsigned req_cycles, req_rises;
  logic [31:0] last_lmd, last_hi, last_wdata;
  logic [3:0]  last_be;

  // Contents of never-written memory words, shared by model and memory.
  function automatic logic [31:0] init_word(input logic [31:0] wa);
    return (wa * 32'h9E3779B1) ^ 32'h5A5A5A5A;
  endfunction

  function automatic logic [31:0] model_rd(input logic [31:0] wa);
    if (model_mem.exists(wa)) return model_mem[wa];
    return init_word(wa);
  endfunction

  function automatic logic [31:0] bus_rd(input logic [31:0] wa);
    if (bus_mem.exists(wa)) return bus_mem[wa];
    return init_word(wa);
  endfunction

  function automatic int mem_beats(input logic [31:0] ir, input logic [31:0] a);
    logic [5:0] op;
    op = ir[31:26];
    case (op)
      OP_LW, OP_SW: return (a[1:0] == 2'b00) ? 1 : 0;
      OP_LH, OP_SH: return (a[0] == 1'b0) ? 1 : 0;
      OP_LD, OP_SD: return (a[1:0] == 2'b00) ? 2 : 0;
      default:      return 0;
    endcase
  endfunction

  task automatic preload(input logic [31:0] wa, input logic [31:0] v);
    model_mem[wa] = v;
    bus_mem[wa]   = v;
  endtask

  task automatic clear_prog();
    p_ir.delete(); p_pc.delete(); p_z.delete(); p_addr.delete();
  endtask

  task automatic add_instr(input logic [5:0] op, input logic [31:0] z, input logic [31:0] a);
    logic [25:0] lo;
    lo = 26'($urandom) | 26'h1;
    p_ir.push_back({op, lo});
    p_pc.push_back(30'($urandom));
    p_z.push_back(z);
    p_addr.push_back(a);
  endtask

  // Instruction-level model: what each instruction should retire as, and
  // which memory beats it should produce, in program order.
  task automatic build_expect(output int mis);
    logic [5:0]  op;
    logic [31:0] a, wa, z, w, lmd;
    logic [15:0] h;
    mis = 0;
    for (int i = 0; i < p_ir.size(); i++) begin
      op = p_ir[i][31:26];
      a  = p_addr[i];
      z  = p_z[i];
      wa = {a[31:2], 2'b00};
      if (op inside {OP_LW, OP_LH, OP_LD, OP_SW, OP_SH, OP_SD} && mem_beats(p_ir[i], a) == 0) begin
        mis++;
      end else begin
        case (op)
          OP_LW: begin
            exp_txn.push_back('{1'b0, wa, 4'hF, 32'h0});
            exp_ret.push_back('{p_ir[i], p_pc[i], z, model_rd(wa), 32'h0});
          end
          OP_LH: begin
            w   = model_rd(wa);
            h   = a[1] ? w[31:16] : w[15:0];
            lmd = {{16{h[15]}}, h};
            exp_txn.push_back('{1'b0, wa, a[1] ? 4'hC : 4'h3, 32'h0});
            exp_ret.push_back('{p_ir[i], p_pc[i], z, lmd, 32'h0});
          end
          OP_LD: begin
            exp_txn.push_back('{1'b0, wa, 4'hF, 32'h0});
            exp_txn.push_back('{1'b0, wa + 32'd4, 4'hF, 32'h0});
            exp_ret.push_back('{p_ir[i], p_pc[i], z, model_rd(wa), model_rd(wa + 32'd4)});
          end
          OP_SW: begin
            exp_txn.push_back('{1'b1, wa, 4'hF, z});
            model_mem[wa] = z;
            exp_ret.push_back('{p_ir[i], p_pc[i], z, 32'h0, 32'h0});
          end
          OP_SH: begin
            w = model_rd(wa);
            exp_txn.push_back('{1'b1, wa, a[1] ? 4'hC : 4'h3, {z[15:0], z[15:0]}});
            model_mem[wa] = a[1] ? {z[15:0], w[15:0]} : {w[31:16], z[15:0]};
            exp_ret.push_back('{p_ir[i], p_pc[i], z, 32'h0, 32'h0});
          end
          OP_SD: begin
            exp_txn.push_back('{1'b1, wa, 4'hF, z});
            exp_txn.push_back('{1'b1, wa + 32'd4, 4'hF, 32'h0});
            model_mem[wa]          = z;
            model_mem[wa + 32'd4]  = 32'h0;
            exp_ret.push_back('{p_ir[i], p_pc[i], z, 32'h0, 32'h0});
          end
          default: exp_ret.push_back('{p_ir[i], p_pc[i], z, 32'h0, 32'h0});
        endcase
      end
    end
  endtask

  // Runs the loaded program; entered and left just after a rising edge.
  // wait_mode < 0 picks a random ack delay of 0..3 cycles per beat.
  task automatic run_prog(input string tag, input int wait_mode);
    int          n, idx, beats_acked, age, dly, cyc, drain, budget, nb, mis_exp, mis_seen;
    logic        ack_now, exp_stall, stall_s, prev_req;
    logic [31:0] w;
    txn_t        t;
    ret_t        act, e;
    exp_ret.delete();
    exp_txn.delete();
    build_expect(mis_exp);
    n = p_ir.size();
    idx = 0; beats_acked = 0; age = 0; dly = 0; cyc = 0; drain = 0; mis_seen = 0;
    req_cycles = 0; req_rises = 0; prev_req = 1'b0;
    budget = n * 20 + 20;
    while ((idx < n || drain < 3) && cyc < budget) begin
      if (idx < n) begin
        IR_in = p_ir[idx]; PC_in = p_pc[idx]; Z_in = p_z[idx]; Addr_in = p_addr[idx];
      end else begin
        IR_in = NOP; PC_in = '0; Z_in = '0; Addr_in = '0;
      end
      ack_now   = 1'b0;
      mem_ack   = 1'b0;
      mem_rdata = $urandom;
      if (mem_req === 1'b1) begin
        req_cycles++;
        if (!prev_req) req_rises++;
        if (age == 0) dly = (wait_mode < 0) ? int'($urandom_range(0, 3)) : wait_mode;
        n_checks++;
        if (exp_txn.size() == 0) begin
          $display("FAIL %s txn_extra: req with addr=%h be=%h, required no request", tag, mem_addr, mem_be);
        end else begin
          t = exp_txn[0];
          if (mem_we !== t.we || mem_addr !== t.addr || mem_be !== t.be ||
              (t.we && mem_wdata !== t.wdata))
            $display("FAIL %s txn: we=%b addr=%h be=%h wdata=%h, required we=%b addr=%h be=%h wdata=%h",
                     tag, mem_we, mem_addr, mem_be, mem_wdata, t.we, t.addr, t.be, t.wdata);
          else
            n_pass++;
          if (age == dly) begin
            ack_now = 1'b1;
            mem_ack = 1'b1;
            last_be = mem_be;
            last_wdata = mem_wdata;
            if (mem_we !== 1'b1) begin
              mem_rdata = bus_rd(mem_addr);
            end else begin
              w = bus_rd(mem_addr);
              for (int b = 0; b < 4; b++)
                if (mem_be[b]) w[8*b +: 8] = mem_wdata[8*b +: 8];
              bus_mem[mem_addr] = w;
            end
            void'(exp_txn.pop_front());
            age = 0;
          end else begin
            age++;
          end
        end
      end
      prev_req  = (mem_req === 1'b1);
      nb        = (idx < n) ? mem_beats(p_ir[idx], p_addr[idx]) : 0;
      exp_stall = (nb != 0) && !(ack_now && (beats_acked + 1 == nb));
      @(negedge clk);
      n_checks++;
      if (MemStall !== exp_stall)
        $display("FAIL %s stall: MemStall=%b, required %b (cycle %0d)", tag, MemStall, exp_stall, cyc);
      else
        n_pass++;
      if (IR_out !== NOP) begin
        act = '{IR_out, PC_out, Z_out, LMD, LMD_hi};
        last_lmd = LMD;
        last_hi  = LMD_hi;
        n_checks++;
        if (exp_ret.size() == 0) begin
          $display("FAIL %s retire_extra: IR_out=%h, required NOP", tag, IR_out);
        end else begin
          e = exp_ret.pop_front();
          if (act !== e)
            $display("FAIL %s retire: ir=%h pc=%h z=%h lmd=%h hi=%h, required ir=%h pc=%h z=%h lmd=%h hi=%h",
                     tag, act.ir, act.pc, act.z, act.lmd, act.hi, e.ir, e.pc, e.z, e.lmd, e.hi);
          else
            n_pass++;
        end
      end
      if (MisAlign === 1'b1) mis_seen++;
      stall_s = MemStall;
      @(posedge clk);
      #1;
      mem_ack = 1'b0;
      if (ack_now) beats_acked++;
      if (stall_s !== 1'b1) begin
        if (idx < n) idx++;
        else drain++;
        beats_acked = 0;
      end
      cyc++;
    end
    n_checks++;
    if (cyc >= budget) $display("FAIL %s timeout: ran %0d cycles, required under %0d", tag, cyc, budget);
    else n_pass++;
    n_checks++;
    if (mis_seen != mis_exp) $display("FAIL %s misalign: pulses=%0d, required %0d", tag, mis_seen, mis_exp);
    else n_pass++;
    n_checks++;
    if (exp_ret.size() != 0 || exp_txn.size() != 0)
      $display("FAIL %s drain: missing retires=%0d beats=%0d, required 0/0", tag, exp_ret.size(), exp_txn.size());
    else n_pass++;
  endtask

  task automatic test_reset();
    rst = 1'b1; mem_ack = 1'b0; mem_rdata = $urandom;
    IR_in = {OP_LW, 26'h0}; PC_in = 30'h1234; Z_in = 32'h55; Addr_in = 32'h100;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (IR_out !== NOP || PC_out !== '0 || Z_out !== '0 || LMD !== '0 || LMD_hi !== '0)
      $display("FAIL reset_outputs: ir=%h pc=%h z=%h lmd=%h hi=%h, required all zero", IR_out, PC_out, Z_out, LMD, LMD_hi);
    else n_pass++;
    n_checks++;
    if (mem_req !== 1'b0 || mem_we !== 1'b0 || mem_be !== '0 || mem_addr !== '0 || mem_wdata !== '0 || MisAlign !== 1'b0)
      $display("FAIL reset_mem: req=%b we=%b be=%h addr=%h wdata=%h mis=%b, required all zero",
               mem_req, mem_we, mem_be, mem_addr, mem_wdata, MisAlign);
    else n_pass++;
    rst = 1'b0;
    IR_in = NOP; PC_in = '0; Z_in = '0; Addr_in = '0;
  endtask

  task automatic test_passthrough();
    clear_prog();
    add_instr(6'h00, 32'd5, 32'h0);
    add_instr(6'h08, 32'hCAFE_0001, 32'h3);
    add_instr(6'h00, 32'h7, 32'h1);
    run_prog("passthrough", 0);
  endtask

  task automatic test_lw();
    preload(32'h100, 32'hDEADBEEF);
    clear_prog();
    add_instr(OP_LW, 32'h0, 32'h100);
    run_prog("lw", 2);
    n_checks++;
    if (last_lmd !== 32'hDEADBEEF) $display("FAIL lw_data: LMD=%h, required deadbeef", last_lmd);
    else n_pass++;
    n_checks++;
    if (req_cycles != 3) $display("FAIL lw_req_len: mem_req high %0d cycles, required 3", req_cycles);
    else n_pass++;
  endtask

  task automatic test_half();
    preload(32'h100, 32'h8001_0000);
    clear_prog();
    add_instr(OP_LH, 32'h0, 32'h102);
    run_prog("lh", 1);
    n_checks++;
    if (last_lmd !== 32'hFFFF8001 || last_be !== 4'b1100)
      $display("FAIL lh_data: LMD=%h be=%h, required ffff8001 c", last_lmd, last_be);
    else n_pass++;
    clear_prog();
    add_instr(OP_SH, 32'h1234, 32'h102);
    add_instr(OP_LW, 32'h0, 32'h100);
    run_prog("sh", 0);
    n_checks++;
    if (last_lmd !== 32'h1234_0000)
      $display("FAIL sh_merge: readback=%h, required 12340000", last_lmd);
    else n_pass++;
  endtask

  task automatic test_sh_lanes();
    clear_prog();
    add_instr(OP_SH, 32'hABCD_1234, 32'h102);
    run_prog("sh_lane", 0);
    n_checks++;
    if (last_wdata !== 32'h12341234 || last_be !== 4'b1100)
      $display("FAIL sh_lanes: wdata=%h be=%h, required 12341234 c", last_wdata, last_be);
    else n_pass++;
  endtask

  task automatic test_ld();
    preload(32'h200, 32'h1111_2222);
    preload(32'h204, 32'h3333_4444);
    clear_prog();
    add_instr(OP_LD, 32'h9, 32'h200);
    run_prog("ld", 1);
    n_checks++;
    if (last_lmd !== 32'h1111_2222 || last_hi !== 32'h3333_4444)
      $display("FAIL ld_data: LMD=%h LMD_hi=%h, required 11112222 33334444", last_lmd, last_hi);
    else n_pass++;
    n_checks++;
    if (req_rises != 1 || req_cycles != 4)
      $display("FAIL ld_req_cont: rises=%0d cycles=%0d, required 1 4", req_rises, req_cycles);
    else n_pass++;
  endtask

  task automatic test_misalign();
    clear_prog();
    add_instr(OP_LW, 32'h0, 32'h101);
    add_instr(OP_SH, 32'h1, 32'h203);
    add_instr(6'h00, 32'h2, 32'h0);
    run_prog("misalign", 0);
    n_checks++;
    if (req_cycles != 0) $display("FAIL misalign_req: mem_req high %0d cycles, required 0", req_cycles);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int k;
    IR_in = {OP_LW, 26'h5}; PC_in = 30'h77; Z_in = 32'h0; Addr_in = 32'h100;
    mem_ack = 1'b0;
    k = 0;
    while (mem_req !== 1'b1 && k < 5) begin
      @(posedge clk); #1;
      k++;
    end
    n_checks++;
    if (mem_req !== 1'b1) $display("FAIL rst_mid_start: mem_req=%b, required 1", mem_req);
    else n_pass++;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_checks++;
    if (mem_req !== 1'b0 || IR_out !== NOP)
      $display("FAIL rst_mid: mem_req=%b IR_out=%h, required 0 %h", mem_req, IR_out, NOP);
    else n_pass++;
    IR_in = NOP; PC_in = '0; Addr_in = '0;
    mem_ack = 1'b1; mem_rdata = $urandom;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    n_checks++;
    if (mem_req !== 1'b0 || IR_out !== NOP || LMD !== '0)
      $display("FAIL rst_stray_ack: mem_req=%b IR_out=%h LMD=%h, required 0 %h 0", mem_req, IR_out, LMD, NOP);
    else n_pass++;
    clear_prog();
    add_instr(6'h00, 32'h42, 32'h0);
    run_prog("after_rst", 0);
  endtask

  task automatic test_random();
    logic [5:0]  ops [8];
    logic [31:0] a;
    int          k;
    ops = '{6'h00, 6'h0F, OP_LW, OP_LH, OP_LD, OP_SW, OP_SH, OP_SD};
    clear_prog();
    for (int i = 0; i < 60; i++) begin
      k = int'($urandom_range(0, 7));
      a = 32'h300 + 32'($urandom_range(0, 63));
      if ($urandom_range(0, 3) != 0) begin
        if (ops[k] == OP_LH || ops[k] == OP_SH) a[0] = 1'b0;
        else a[1:0] = 2'b00;
      end
      add_instr(ops[k], $urandom, a);
    end
    run_prog("random", -1);
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_lw();
    test_half();
    test_sh_lanes();
    test_ld();
    test_misalign();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
